// File: rtl/regfile_wr_decode.sv
// regfile_wr_decode: 32 x WIDTH register file with a one-hot write decode, two 32:1 read selects and a hard-wired zero register
//   clk           : rising-edge clock for all register updates
//   reset         : asynchronous active-low clear of every register
//   RegWrite      : write enable for this cycle
//   WriteRegister : destination register index
//   WriteData     : data captured into the destination register
//   ReadRegister1 : read port 1 index
//   ReadRegister2 : read port 2 index
//   ReadData1     : read port 1 data (combinational)
//   ReadData2     : read port 2 data (combinational)
module regfile_wr_decode #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);
    logic [31:0]      en;
    logic [WIDTH-1:0] regs [32];
    logic             hit1, hit2;

    // Zero register never gets an enable, so its flops stay at their reset value of 0.
    assign en = {32{RegWrite}} & (32'd1 << WriteRegister) & ~(32'd1 << ZERO_REG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 32; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < 32; k++) if (en[k]) regs[k] <= WriteData;
        end
    end

    // Five levels of 2:1 muxes, level l steered by address bit l.
    // Writing t[i] is safe: later reads at this level use indices >= 2*(i+1).
    function automatic logic [WIDTH-1:0] sel32(input logic [WIDTH-1:0] v [32], input logic [4:0] a);
        logic [WIDTH-1:0] t [32];
        t = v;
        for (int l = 0; l < 5; l++)
            for (int i = 0; i < (16 >> l); i++)
                t[i] = a[l] ? t[2*i+1] : t[2*i];
        return t[0];
    endfunction

    assign hit1 = (BYPASS != 0) && RegWrite && (ReadRegister1 == WriteRegister) && (WriteRegister != 5'(ZERO_REG));
    assign hit2 = (BYPASS != 0) && RegWrite && (ReadRegister2 == WriteRegister) && (WriteRegister != 5'(ZERO_REG));

    always_comb begin
        ReadData1 = hit1 ? WriteData : sel32(regs, ReadRegister1);
        ReadData2 = hit2 ? WriteData : sel32(regs, ReadRegister2);
    end
endmodule

// File: tb/tb_regfile_wr_decode.sv
// tb_regfile_wr_decode: directed checks of the register file with and without write-to-read bypass
module tb_regfile_wr_decode;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [63:0] WriteData = '0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
    int          n_tests = 0;
    int          n_fail = 0;

    always #50 clk = ~clk;

    regfile_wr_decode #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_b), .ReadData2(rd2_b)
    );

    regfile_wr_decode #(.WIDTH(64), .ZERO_REG(31), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_n), .ReadData2(rd2_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] wr, input logic [63:0] wd);
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = wr;
        WriteData = wd;
        @(posedge clk);
        #1 RegWrite = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), rd1_b, 64'h0);
            check($sformatf("reset_rd2_r%0d", 31 - i), rd2_b, 64'h0);
        end

        do_write(5'd5, 64'h0000_0000_DEAD_BEEF);
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd6;
        #1;
        check("wr_r5_byp", rd1_b, 64'hDEADBEEF);
        check("wr_r5_nob", rd1_n, 64'hDEADBEEF);
        check("rd_r6_byp", rd2_b, 64'h0);
        check("rd_r6_nob", rd2_n, 64'h0);

        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd31;
        WriteData = '1;
        ReadRegister1 = 5'd31;
        #1;
        check("zero_same_byp", rd1_b, 64'h0);
        check("zero_same_nob", rd1_n, 64'h0);
        @(posedge clk);
        #1 RegWrite = 1'b0;
        #1;
        check("zero_next_byp", rd1_b, 64'h0);
        check("zero_next_nob", rd1_n, 64'h0);

        do_write(5'd7, 64'h11);
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd7;
        WriteData = 64'h22;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        #1;
        check("bypass_rd1", rd1_b, 64'h22);
        check("bypass_rd2", rd2_b, 64'h22);
        check("nobypass_rd1_old", rd1_n, 64'h11);
        check("nobypass_rd2_old", rd2_n, 64'h11);
        @(posedge clk);
        #1 RegWrite = 1'b0;
        #1;
        check("nobypass_rd1_new", rd1_n, 64'h22);
        check("nobypass_rd2_new", rd2_n, 64'h22);
        check("bypass_rd1_held", rd1_b, 64'h22);

        @(negedge clk);
        RegWrite = 1'b0;
        WriteRegister = 5'd3;
        WriteData = 64'hAB;
        ReadRegister1 = 5'd3;
        #1;
        check("gate_same_byp", rd1_b, 64'h0);
        @(posedge clk);
        #1;
        check("gate_byp", rd1_b, 64'h0);
        check("gate_nob", rd1_n, 64'h0);

        for (int k = 0; k < 31; k++) do_write(5'(k), 64'h1000 + 64'(k) * 64'h0101);
        ReadRegister1 = 5'd30;
        ReadRegister2 = 5'd0;
        #1;
        check("fill_r30", rd1_n, 64'h1000 + 64'd30 * 64'h0101);
        check("fill_r0", rd2_b, 64'h1000);

        #10 reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(i);
            #1;
            check($sformatf("async_rd1_r%0d", i), rd1_b, 64'h0);
            check($sformatf("async_rd2_r%0d", i), rd2_n, 64'h0);
        end

        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd2;
        WriteData = 64'h99;
        ReadRegister1 = 5'd2;
        #1;
        check("rst_bypass_byp", rd1_b, 64'h99);
        check("rst_bypass_nob", rd1_n, 64'h0);
        @(posedge clk);
        #1 RegWrite = 1'b0;
        #1;
        check("rst_write_blocked_byp", rd1_b, 64'h0);
        check("rst_write_blocked_nob", rd1_n, 64'h0);

        @(negedge clk);
        reset = 1'b1;
        do_write(5'd2, 64'h55);
        ReadRegister1 = 5'd2;
        ReadRegister2 = 5'd1;
        #1;
        check("post_rst_r2_byp", rd1_b, 64'h55);
        check("post_rst_r2_nob", rd1_n, 64'h55);
        check("post_rst_r1_cleared", rd2_n, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
